// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the memory stage: data width, RISC-V load/store funct3
// encodings and the load/store unit state type.
package load_store_unit_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic {
        LSU_IDLE  = 1'b0,
        LSU_BEAT1 = 1'b1
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit_load_align.sv
// Load data alignment: selects the addressed bytes from a two-word window and
// sign- or zero-extends them according to funct3.
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [2*DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]              off_i,
    input  logic [2:0]              funct3_i,
    output logic [DATA_WIDTH-1:0]   result_o
);

    logic [DATA_WIDTH-1:0] word;
    logic signed [7:0]     byte_s;
    logic signed [15:0]    half_s;

    assign word   = DATA_WIDTH'(rdata_i >> {off_i, 3'b000});
    assign byte_s = word[7:0];
    assign half_s = word[15:0];

    always_comb begin
        result_o = '0;
        case (funct3_i)
            FUNCT3_LB:  result_o = DATA_WIDTH'(byte_s);
            FUNCT3_LH:  result_o = DATA_WIDTH'(half_s);
            FUNCT3_LW:  result_o = word;
            FUNCT3_LBU: result_o = {24'h0, word[7:0]};
            FUNCT3_LHU: result_o = {16'h0, word[15:0]};
            default:    result_o = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store initiator: drives a word-addressed, byte-enabled data
// port and splits misaligned halfword/word accesses into two word beats.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o,
    output logic                  mem_re_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    lsu_state_t state;

    logic [1:0]              off_p0;
    logic [2:0]              size_p0;
    logic [3:0]              size_mask_p0;
    logic                    legal_p0;
    logic                    misaligned_p0;
    logic [DATA_WIDTH-1:0]   addr0_p0;
    logic [DATA_WIDTH-1:0]   addr1_p0;
    logic [2*DATA_WIDTH-1:0] st_data_p0;
    logic [7:0]              st_mask_p0;

    logic [DATA_WIDTH-1:0]   cap_rdata0_p1;
    logic [1:0]              cap_off_p1;
    logic [2:0]              cap_funct3_p1;
    logic                    cap_we_p1;
    logic [DATA_WIDTH-1:0]   cap_addr1_p1;
    logic [DATA_WIDTH-1:0]   cap_wdata1_p1;
    logic [3:0]              cap_be1_p1;

    logic [2*DATA_WIDTH-1:0] align_rdata;
    logic [1:0]              align_off;
    logic [2:0]              align_funct3;
    logic [DATA_WIDTH-1:0]   align_result;

    // Stage p0: decode of the incoming request
    assign off_p0 = addr_i[1:0];

    always_comb begin
        case (funct3_i[1:0])
            2'b00:   begin size_p0 = 3'd1; size_mask_p0 = 4'b0001; end
            2'b01:   begin size_p0 = 3'd2; size_mask_p0 = 4'b0011; end
            default: begin size_p0 = 3'd4; size_mask_p0 = 4'b1111; end
        endcase
    end

    always_comb begin
        if (req_we_i)
            legal_p0 = (funct3_i == FUNCT3_SB) || (funct3_i == FUNCT3_SH) ||
                       (funct3_i == FUNCT3_SW);
        else
            legal_p0 = (funct3_i == FUNCT3_LB) || (funct3_i == FUNCT3_LH) ||
                       (funct3_i == FUNCT3_LW) || (funct3_i == FUNCT3_LBU) ||
                       (funct3_i == FUNCT3_LHU);
    end

    assign misaligned_p0 = legal_p0 && (({1'b0, off_p0} + size_p0) > 3'd4);
    assign addr0_p0      = {addr_i[DATA_WIDTH-1:2], 2'b00};
    assign addr1_p0      = addr0_p0 + DATA_WIDTH'(4);
    assign st_data_p0    = {{DATA_WIDTH{1'b0}}, wdata_i} << {off_p0, 3'b000};
    assign st_mask_p0    = {4'b0000, size_mask_p0} << off_p0;

    assign req_ready_o = (state == LSU_IDLE);

    always_comb begin
        mem_addr_o  = addr0_p0;
        mem_wdata_o = st_data_p0[DATA_WIDTH-1:0];
        mem_be_o    = 4'b0000;
        mem_re_o    = 1'b0;
        mem_we_o    = 1'b0;
        if (state == LSU_BEAT1) begin
            mem_addr_o  = cap_addr1_p1;
            mem_wdata_o = cap_wdata1_p1;
            mem_be_o    = cap_be1_p1;
            mem_re_o    = !cap_we_p1;
            mem_we_o    = cap_we_p1;
        end else if (req_valid_i && legal_p0) begin
            mem_be_o = st_mask_p0[3:0];
            mem_re_o = !req_we_i;
            mem_we_o = req_we_i;
        end
    end

    // In BEAT1 the window is {beat1, captured beat0}; aligned loads see one word.
    always_comb begin
        if (state == LSU_BEAT1) begin
            align_rdata  = {mem_rdata_i, cap_rdata0_p1};
            align_off    = cap_off_p1;
            align_funct3 = cap_funct3_p1;
        end else begin
            align_rdata  = {{DATA_WIDTH{1'b0}}, mem_rdata_i};
            align_off    = off_p0;
            align_funct3 = funct3_i;
        end
    end

    lsu_load_align u_load_align (
        .rdata_i  (align_rdata),
        .off_i    (align_off),
        .funct3_i (align_funct3),
        .result_o (align_result)
    );

    // Stage p1: beat-1 capture and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= LSU_IDLE;
            resp_valid_o  <= 1'b0;
            resp_rdata_o  <= '0;
            resp_err_o    <= 1'b0;
            cap_rdata0_p1 <= '0;
            cap_off_p1    <= 2'b00;
            cap_funct3_p1 <= 3'b000;
            cap_we_p1     <= 1'b0;
            cap_addr1_p1  <= '0;
            cap_wdata1_p1 <= '0;
            cap_be1_p1    <= 4'b0000;
        end else begin
            resp_valid_o <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= '0;
            case (state)
                LSU_IDLE: begin
                    if (req_valid_i) begin
                        if (!legal_p0) begin
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                        end else if (misaligned_p0) begin
                            cap_rdata0_p1 <= mem_rdata_i;
                            cap_off_p1    <= off_p0;
                            cap_funct3_p1 <= funct3_i;
                            cap_we_p1     <= req_we_i;
                            cap_addr1_p1  <= addr1_p0;
                            cap_wdata1_p1 <= st_data_p0[2*DATA_WIDTH-1:DATA_WIDTH];
                            cap_be1_p1    <= st_mask_p0[7:4];
                            state         <= LSU_BEAT1;
                        end else begin
                            resp_valid_o <= 1'b1;
                            resp_rdata_o <= req_we_i ? '0 : align_result;
                        end
                    end
                end
                LSU_BEAT1: begin
                    resp_valid_o <= 1'b1;
                    resp_rdata_o <= cap_we_p1 ? '0 : align_result;
                    state        <= LSU_IDLE;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small byte-enabled word memory model.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        mem_re_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    int checks = 0;
    int failures = 0;

    // Word memory indexed by addr[4:2]: 0x0->0, 0x4->1, 0x8->2, 0xFFFFFFFC->7
    logic [31:0] mem_words [8];
    logic        pl_en = 1'b0;
    logic [2:0]  pl_idx = 3'd0;
    logic [31:0] pl_val = 32'h0;

    load_store_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o),
        .mem_re_o     (mem_re_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk = ~clk;

    assign mem_rdata_i = mem_words[mem_addr_o[4:2]];

    always @(posedge clk) begin
        if (pl_en)
            mem_words[pl_idx] <= pl_val;
        else if (mem_we_o)
            for (int i = 0; i < 4; i++)
                if (mem_be_o[i]) mem_words[mem_addr_o[4:2]][8*i +: 8] <= mem_wdata_o[8*i +: 8];
    end

    task automatic mem_set(input logic [2:0] idx, input logic [31:0] val);
        pl_idx = idx; pl_val = val; pl_en = 1'b1;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid_i = v; req_we_i = we; funct3_i = f3; addr_i = a; wdata_i = d;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (resp_valid_o !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid_o); end
        checks++; if (resp_rdata_o !== 32'h0) begin failures++; $display("FAIL rst_resp_rdata got %h exp 00000000", resp_rdata_o); end
        checks++; if (resp_err_o !== 1'b0) begin failures++; $display("FAIL rst_resp_err got %b exp 0", resp_err_o); end
        checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready got %b exp 1", req_ready_o); end
        checks++; if ({mem_re_o, mem_we_o, mem_be_o} !== 6'b0) begin failures++; $display("FAIL rst_port_quiet got %b exp 000000", {mem_re_o, mem_we_o, mem_be_o}); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (resp_valid_o !== 1'b0) begin failures++; $display("FAIL post_rst_valid got %b exp 0", resp_valid_o); end
    endtask

    task automatic test_sw_misaligned;
        mem_set(3'd1, 32'h0); mem_set(3'd2, 32'h0);
        drive(1'b1, 1'b1, FUNCT3_SW, 32'h6, 32'hAABBCCDD);
        #1;
        checks++; if (mem_addr_o !== 32'h4) begin failures++; $display("FAIL sw_b0_addr got %h exp 00000004", mem_addr_o); end
        checks++; if (mem_be_o !== 4'b1100) begin failures++; $display("FAIL sw_b0_be got %b exp 1100", mem_be_o); end
        checks++; if (mem_wdata_o !== 32'hCCDD0000) begin failures++; $display("FAIL sw_b0_wdata got %h exp ccdd0000", mem_wdata_o); end
        checks++; if ({mem_we_o, mem_re_o} !== 2'b10) begin failures++; $display("FAIL sw_b0_strobes got %b exp 10", {mem_we_o, mem_re_o}); end
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        checks++; if (mem_addr_o !== 32'h8) begin failures++; $display("FAIL sw_b1_addr got %h exp 00000008", mem_addr_o); end
        checks++; if (mem_be_o !== 4'b0011) begin failures++; $display("FAIL sw_b1_be got %b exp 0011", mem_be_o); end
        checks++; if (mem_wdata_o !== 32'h0000AABB) begin failures++; $display("FAIL sw_b1_wdata got %h exp 0000aabb", mem_wdata_o); end
        checks++; if (req_ready_o !== 1'b0) begin failures++; $display("FAIL sw_b1_ready got %b exp 0", req_ready_o); end
        checks++; if (resp_valid_o !== 1'b0) begin failures++; $display("FAIL sw_t1_valid got %b exp 0", resp_valid_o); end
        @(negedge clk);
        checks++; if ({resp_valid_o, resp_err_o} !== 2'b10) begin failures++; $display("FAIL sw_resp got %b exp 10", {resp_valid_o, resp_err_o}); end
        checks++; if (resp_rdata_o !== 32'h0) begin failures++; $display("FAIL sw_resp_rdata got %h exp 00000000", resp_rdata_o); end
        checks++; if (mem_words[1] !== 32'hCCDD0000) begin failures++; $display("FAIL sw_mem4 got %h exp ccdd0000", mem_words[1]); end
        checks++; if (mem_words[2] !== 32'h0000AABB) begin failures++; $display("FAIL sw_mem8 got %h exp 0000aabb", mem_words[2]); end
    endtask

    task automatic test_back_to_back;
        mem_set(3'd1, 32'h80FF1234);
        drive(1'b1, 1'b0, FUNCT3_LB, 32'h7, 32'h0);
        #1;
        checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL lb_ready got %b exp 1", req_ready_o); end
        checks++; if ({mem_re_o, mem_be_o} !== 5'b11000) begin failures++; $display("FAIL lb_port got %b exp 11000", {mem_re_o, mem_be_o}); end
        @(negedge clk);
        checks++; if (resp_valid_o !== 1'b1) begin failures++; $display("FAIL lb_valid got %b exp 1", resp_valid_o); end
        checks++; if (resp_rdata_o !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_rdata got %h exp ffffff80", resp_rdata_o); end
        drive(1'b1, 1'b0, FUNCT3_LBU, 32'h7, 32'h0);
        #1;
        checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL lbu_ready got %b exp 1", req_ready_o); end
        @(negedge clk);
        checks++; if (resp_valid_o !== 1'b1) begin failures++; $display("FAIL lbu_valid got %b exp 1", resp_valid_o); end
        checks++; if (resp_rdata_o !== 32'h00000080) begin failures++; $display("FAIL lbu_rdata got %h exp 00000080", resp_rdata_o); end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        checks++; if (resp_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_idle_valid got %b exp 0", resp_valid_o); end
    endtask

    task automatic test_lh_misaligned;
        mem_set(3'd1, 32'h80FF1234); mem_set(3'd2, 32'h000000A5);
        drive(1'b1, 1'b0, FUNCT3_LH, 32'h7, 32'h0);
        #1;
        checks++; if ({mem_addr_o, mem_be_o, mem_re_o} !== {32'h4, 4'b1000, 1'b1}) begin failures++; $display("FAIL lh_b0 got %h/%b/%b exp 00000004/1000/1", mem_addr_o, mem_be_o, mem_re_o); end
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        checks++; if ({mem_addr_o, mem_be_o, mem_re_o} !== {32'h8, 4'b0001, 1'b1}) begin failures++; $display("FAIL lh_b1 got %h/%b/%b exp 00000008/0001/1", mem_addr_o, mem_be_o, mem_re_o); end
        checks++; if (req_ready_o !== 1'b0) begin failures++; $display("FAIL lh_b1_ready got %b exp 0", req_ready_o); end
        @(negedge clk);
        checks++; if (resp_valid_o !== 1'b1) begin failures++; $display("FAIL lh_valid got %b exp 1", resp_valid_o); end
        checks++; if (resp_rdata_o !== 32'hFFFFA580) begin failures++; $display("FAIL lh_rdata got %h exp ffffa580", resp_rdata_o); end
    endtask

    task automatic test_lw_wrap;
        mem_set(3'd7, 32'h11223344); mem_set(3'd0, 32'h55667788);
        drive(1'b1, 1'b0, FUNCT3_LW, 32'hFFFFFFFE, 32'h0);
        #1;
        checks++; if ({mem_addr_o, mem_be_o} !== {32'hFFFFFFFC, 4'b1100}) begin failures++; $display("FAIL lw_b0 got %h/%b exp fffffffc/1100", mem_addr_o, mem_be_o); end
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        checks++; if ({mem_addr_o, mem_be_o} !== {32'h0, 4'b0011}) begin failures++; $display("FAIL lw_b1 got %h/%b exp 00000000/0011", mem_addr_o, mem_be_o); end
        @(negedge clk);
        checks++; if ({resp_valid_o, resp_rdata_o} !== {1'b1, 32'h77881122}) begin failures++; $display("FAIL lw_wrap_resp got %b/%h exp 1/77881122", resp_valid_o, resp_rdata_o); end
    endtask

    task automatic test_illegal;
        drive(1'b1, 1'b1, 3'b011, 32'h4, 32'hDEADBEEF);
        #1;
        checks++; if ({mem_re_o, mem_we_o, mem_be_o} !== 6'b0) begin failures++; $display("FAIL ill_st_port got %b exp 000000", {mem_re_o, mem_we_o, mem_be_o}); end
        @(negedge clk);
        checks++; if ({resp_valid_o, resp_err_o, resp_rdata_o} !== {2'b11, 32'h0}) begin failures++; $display("FAIL ill_st_resp got %b/%b/%h exp 1/1/00000000", resp_valid_o, resp_err_o, resp_rdata_o); end
        drive(1'b1, 1'b0, 3'b110, 32'h4, 32'h0);
        #1;
        checks++; if ({mem_re_o, mem_we_o, mem_be_o} !== 6'b0) begin failures++; $display("FAIL ill_ld_port got %b exp 000000", {mem_re_o, mem_we_o, mem_be_o}); end
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        checks++; if ({resp_valid_o, resp_err_o, resp_rdata_o} !== {2'b11, 32'h0}) begin failures++; $display("FAIL ill_ld_resp got %b/%b/%h exp 1/1/00000000", resp_valid_o, resp_err_o, resp_rdata_o); end
        @(negedge clk);
        checks++; if ({resp_valid_o, resp_err_o} !== 2'b00) begin failures++; $display("FAIL ill_clear got %b exp 00", {resp_valid_o, resp_err_o}); end
    endtask

    task automatic test_reset_in_beat1;
        mem_set(3'd0, 32'h0); mem_set(3'd1, 32'hCAFEF00D);
        drive(1'b1, 1'b1, FUNCT3_SH, 32'h3, 32'h0000BEEF);
        #1;
        checks++; if ({mem_be_o, mem_wdata_o} !== {4'b1000, 32'hEF000000}) begin failures++; $display("FAIL sh_b0 got %b/%h exp 1000/ef000000", mem_be_o, mem_wdata_o); end
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        checks++; if ({req_ready_o, mem_be_o} !== {1'b0, 4'b0001}) begin failures++; $display("FAIL sh_b1 got %b/%b exp 0/0001", req_ready_o, mem_be_o); end
        rst_n = 1'b0;
        #1;
        checks++; if ({req_ready_o, mem_we_o, resp_valid_o} !== 3'b100) begin failures++; $display("FAIL rstb1_state got %b exp 100", {req_ready_o, mem_we_o, resp_valid_o}); end
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (mem_words[0] !== 32'hEF000000) begin failures++; $display("FAIL rstb1_beat0 got %h exp ef000000", mem_words[0]); end
        checks++; if (mem_words[1] !== 32'hCAFEF00D) begin failures++; $display("FAIL rstb1_beat1 got %h exp cafef00d", mem_words[1]); end
        @(negedge clk);
        checks++; if (resp_valid_o !== 1'b0) begin failures++; $display("FAIL rstb1_no_resp got %b exp 0", resp_valid_o); end
        drive(1'b1, 1'b0, FUNCT3_LW, 32'h4, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        checks++; if ({resp_valid_o, resp_rdata_o} !== {1'b1, 32'hCAFEF00D}) begin failures++; $display("FAIL rstb1_lw got %b/%h exp 1/cafef00d", resp_valid_o, resp_rdata_o); end
    endtask

    initial begin
        test_reset();
        test_sw_misaligned();
        test_back_to_back();
        test_lh_misaligned();
        test_lw_wrap();
        test_illegal();
        test_reset_in_beat1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage initiator for the data memory port. Accepts one load/store request per cycle from the EX/MEM pipeline register and drives the word-addressed, byte-enabled data memory. Splits misaligned halfword and word accesses into two word beats, and returns aligned, sign- or zero-extended load data. Busy cycles are reported back to the hazard unit through `req_ready_o`.

## Interface
- `DATA_WIDTH`, 32 (from `defines`): address and data width; only 32 is supported.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: request accepted when `req_valid_i & req_ready_o`; low means stall the pipeline.
- `req_we_i` in 1: 1 = store, 0 = load.
- `funct3_i` in 3: RISC-V load/store `funct3`.
- `addr_i` in 32: byte address.
- `wdata_i` in 32: store data, right-aligned.
- `resp_valid_o` out 1: one-cycle pulse, one per accepted request.
- `resp_rdata_o` out 32: extended load data; 0 for stores and errors.
- `resp_err_o` out 1: illegal `funct3`; qualified by `resp_valid_o`.
- `mem_re_o`, `mem_we_o` out 1 each: memory read and write strobes.
- `mem_be_o` out 4: byte enables, bit i = byte lane i.
- `mem_addr_o` out 32: word-aligned byte address, so bits [1:0] are always 0.
- `mem_wdata_o` out 32: lane-positioned write data.
- `mem_rdata_i` in 32: combinational read data for the `mem_addr_o` driven in the same cycle.

## Operation
- States: IDLE and BEAT1.
- **IDLE:**
  - `req_ready_o` = 1.
  - The memory port is driven combinationally from the request.
  - With no valid request, `mem_re_o`, `mem_we_o` and `mem_be_o` are all 0.
- **Size and offset:**
  - size = 1/2/4 bytes for `funct3[1:0]` = 00/01/10.
  - off = `addr_i[1:0]`.
  - Misaligned when off + size > 4 (LH/SH at off 3; LW/SW at off 1..3).
- **Legal `funct3`:**
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Any other value gives no memory activity and a response with `resp_err_o` = 1 and `resp_rdata_o` = 0.
- **Store lanes:**
  - 64-bit shifted data = `wdata_i` << 8·off.
  - 8-bit mask = ((1 << size) − 1) << off.
  - Beat 0 uses the low 32 bits / low 4 mask bits.
  - Beat 1 uses the high 32 bits / high 4 mask bits.
- **Load assembly:**
  - Concatenate {beat1 rdata, beat0 rdata} and shift right by 8·off.
  - Keep the low size bytes.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- **Beat addresses:**
  - Beat 0 word = `{addr_i[31:2], 2'b00}`.
  - Beat 1 word = beat 0 word + 4, modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000.
- **Aligned request:**
  - Completes in the acceptance cycle.
  - The response is registered; the unit stays in IDLE.
- **Misaligned request:**
  - Beat 0 issues in the acceptance cycle.
  - Beat 0 rdata, offset, `funct3`, beat 1 address, and beat 1 data/mask are captured in registers.
  - Go to BEAT1.
- **BEAT1:**
  - `req_ready_o` = 0.
  - The port is driven only from the captured registers; request inputs are ignored.
  - The response is registered, then return to IDLE.
- `mem_re_o` = !we for a legal load beat; `mem_we_o` = 1 for a legal store beat.

## Timing
- Reset values:
  - State = IDLE.
  - `resp_valid_o` = 0, `resp_rdata_o` = 0, `resp_err_o` = 0.
  - All capture registers = 0.
  - The port is quiescent until a request arrives.
- Aligned or error request accepted at cycle T: `resp_valid_o` = 1 at T+1; throughput is 1 request per cycle.
- Misaligned request accepted at T:
  - Beat 0 on the port at T.
  - Beat 1 at T+1, with `req_ready_o` = 0 at T+1.
  - `resp_valid_o` at T+2.
  - The next request is accepted no earlier than T+2.
- A store write takes effect at the rising edge ending its beat cycle.
- Reset asserted during BEAT1:
  - The beat is abandoned and no response is produced.
  - A misaligned store may leave beat 0 already written. This is accepted behaviour.
- `req_valid_i` held high during BEAT1 is not accepted and must be held by the pipeline.

## Structure
- Add to `defines`:
  - `FUNCT3_LB`, `FUNCT3_LH`, `FUNCT3_LW`, `FUNCT3_LBU`, `FUNCT3_LHU`, alongside the existing `FUNCT3_SB`/`SH`/`SW`.
  - `lsu_state_t` enum {LSU_IDLE, LSU_BEAT1}.
- Sub-module `lsu_load_align`: combinational; takes the 64-bit concatenated read data, off and `funct3`; produces the extended 32-bit result.

## Test plan
- **SW 0xAABBCCDD at 0x6:**
  - T: addr 0x4, be 1100, wdata 0xCCDD0000.
  - T+1: addr 0x8, be 0011, wdata 0x0000AABB, `req_ready_o` = 0.
  - T+2: response valid.
- **Aligned LB/LBU from 0x7, mem[0x4] = 0x80FF1234:** `resp_rdata_o` = 0xFFFFFF80 / 0x00000080 at T+1; back-to-back issue with no stall.
- **LH at 0x7, mem[0x4] = 0x80FF1234, mem[0x8] = 0x000000A5:** two beats; `resp_rdata_o` = 0xFFFFA580 at T+2.
- **LW at 0xFFFFFFFE:** beat 1 addr = 0x00000000; result = {mem[0x0][15:0], mem[0xFFFFFFFC][31:16]}.
- **Store with `funct3` 3'b011:** `mem_we_o` = 0 and `mem_be_o` = 0; at T+1 `resp_err_o` = 1, `resp_rdata_o` = 0.
- **Reset pulsed during BEAT1 of SH at 0x3:** beat 0 byte written; after release state = IDLE, `resp_valid_o` = 0, and the next aligned LW completes normally.
